// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: shares one downstream ready/valid channel among
// NUM_REQ upstream packet streams. The grant is held for a whole packet, then rotates.
module rr_packet_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            in_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  output logic [NUM_REQ-1:0]            in_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] grant, grant_next;
  logic [ID_WIDTH-1:0] ptr, ptr_next;
  logic [ID_WIDTH-1:0] pick;
  logic                pick_found;
  logic                last_accept;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  // Scan upward from ptr with an explicit wrap, so non-power-of-two counts work.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && in_valid[idx]) begin
        pick       = ID_WIDTH'(idx);
        pick_found = 1'b1;
      end
    end
  end

  assign last_accept = (state == BUSY) && in_valid[grant] && in_last[grant] && out_ready;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_accept) begin
          state_next = IDLE;
          ptr_next   = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + ID_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload and ready pass straight through while a grant is held.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    grant_id  = '0;
    busy      = 1'b0;
    if (state == BUSY) begin
      in_ready[grant] = out_ready;
      out_valid       = in_valid[grant];
      out_data        = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      out_last        = in_valid[grant] & in_last[grant];
      grant_id        = grant;
      busy            = 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: directed scenarios plus randomized
// packet traffic compared against a cycle-level behavioural model of the arbiter.
module tb_rr_packet_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] in_valid, in_last, in_ready;
  logic [NR*DW-1:0] in_data;
  logic          out_valid, out_last, out_ready, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    grant_id;

  logic [2:0]    v3, l3, rdy3;
  logic [23:0]   d3;
  logic          ov3, ol3, busy3, ready3;
  logic [7:0]    od3;
  logic [1:0]    gid3;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Behavioural model: owner index or -1 when no packet grant is held.
  int m_owner;
  int m_ptr;

  logic [NR-1:0] acc_mask;
  logic [NR-1:0] obs_rdy;
  logic          obs_valid, obs_busy;
  logic [DW-1:0] obs_data;
  logic [1:0]    obs_gid;
  int            rem[NR];

  rr_packet_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .grant_id(grant_id), .busy(busy)
  );

  rr_packet_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
    .clk(clk), .reset(reset),
    .in_valid(v3), .in_data(d3), .in_last(l3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_ready(ready3),
    .grant_id(gid3), .busy(busy3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"},  32'(out_data),  32'h0);
    check({tag, "_out_last"},  32'(out_last),  32'h0);
    check({tag, "_grant_id"},  32'(grant_id),  32'h0);
    check({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  // One clock cycle: compare outputs with the model mid-cycle, advance the
  // model as the rising edge would, then return just after that edge.
  task automatic step();
    logic [NR-1:0] e_rdy;
    logic          e_v, e_l, e_busy, found;
    logic [DW-1:0] e_d;
    logic [1:0]    e_gid;
    int            g, idx;
    @(negedge clk);
    obs_rdy = in_ready; obs_valid = out_valid; obs_busy = busy;
    obs_data = out_data; obs_gid = grant_id;
    e_rdy = '0; e_v = 1'b0; e_l = 1'b0; e_d = '0; e_gid = '0; e_busy = 1'b0;
    if (reset && m_owner >= 0) begin
      g      = m_owner;
      e_v    = in_valid[g];
      e_d    = in_data[g*DW +: DW];
      e_l    = in_valid[g] & in_last[g];
      e_rdy  = out_ready ? (4'b0001 << g) : 4'b0000;
      e_busy = 1'b1;
      e_gid  = 2'(g);
    end
    check("in_ready",  32'(in_ready),  32'(e_rdy));
    check("out_valid", 32'(out_valid), 32'(e_v));
    check("out_data",  32'(out_data),  32'(e_d));
    check("out_last",  32'(out_last),  32'(e_l));
    check("grant_id",  32'(grant_id),  32'(e_gid));
    check("busy",      32'(busy),      32'(e_busy));
    acc_mask = e_rdy & in_valid;
    if (!reset) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!found && in_valid[idx]) begin
          m_owner = idx;
          found   = 1'b1;
        end
      end
    end else if (e_v && out_ready && e_l) begin
      m_ptr   = (m_owner + 1) % NR;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  int exp_rr[5] = '{0, 1, 2, 3, 0};
  int exp3[6]   = '{0, 1, 2, 0, 1, 2};

  initial begin
    m_owner = -1;
    m_ptr   = 0;
    v3 = '0; l3 = '0; d3 = '0; ready3 = 1'b0;

    // Reset held with random inputs: every output stays at zero.
    reset     = 1'b0;
    in_valid  = 4'($urandom);
    in_last   = 4'($urandom);
    in_data   = $urandom;
    out_ready = 1'b1;
    #1;
    check_all_zero("reset_async");
    step();
    reset = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
    step();
    step();
    check("idle_after_reset_busy", 32'(obs_busy), 32'h0);

    // Single requester 2, three beats.
    in_valid = 4'b0100; in_last = 4'b0000; in_data = '0; in_data[2*DW +: DW] = 8'hA0;
    step();
    check("single_c0_valid", 32'(obs_valid), 32'h0);
    step();
    check("single_c1_data", 32'(obs_data), 32'hA0);
    check("single_c1_gid",  32'(obs_gid),  32'h2);
    check("single_c1_rdy",  32'(obs_rdy),  32'h4);
    in_data[2*DW +: DW] = 8'hA1;
    step();
    check("single_c2_data", 32'(obs_data), 32'hA1);
    in_data[2*DW +: DW] = 8'hA2; in_last = 4'b0100;
    step();
    check("single_c3_data", 32'(obs_data), 32'hA2);
    check("single_c3_gid",  32'(obs_gid),  32'h2);
    in_valid = '0; in_last = '0;
    step();
    check("single_c4_busy", 32'(obs_busy), 32'h0);

    // Fresh reset so the pointer starts at 0, then rotate single-beat packets.
    reset = 1'b0;
    step();
    reset = 1'b1;
    in_valid = 4'b1111; in_last = 4'b1111; in_data = $urandom;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) in_valid = 4'b1001;
      step();
      if (c % 2 == 1) check("rr_grant", 32'(obs_gid), 32'(exp_rr[c/2]));
      else            check("rr_bubble", 32'(obs_busy), 32'h0);
    end
    in_valid = '0; in_last = '0;
    step();

    // Backpressure and owner stall on requester 1.
    in_valid = 4'b0010; in_last = 4'b0000; in_data[1*DW +: DW] = 8'hB0;
    step();
    step();
    check("bp_first_gid", 32'(obs_gid), 32'h1);
    in_data[1*DW +: DW] = 8'hB1; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_rdy",  32'(obs_rdy),  32'h0);
      check("bp_data", 32'(obs_data), 32'hB1);
    end
    out_ready = 1'b1; in_valid = 4'b0001; in_last = 4'b0001; in_data[0 +: DW] = 8'hC5;
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_valid", 32'(obs_valid), 32'h0);
      check("stall_gid",   32'(obs_gid),   32'h1);
    end
    in_valid = 4'b0011; in_last = 4'b0011;
    step();
    check("stall_last_gid",  32'(obs_gid),  32'h1);
    check("stall_last_data", 32'(obs_data), 32'hB1);
    in_valid = 4'b0001;
    step();
    check("stall_gap_busy", 32'(obs_busy), 32'h0);
    step();
    check("stall_next_gid", 32'(obs_gid), 32'h0);
    in_valid = '0; in_last = '0;
    step();

    // Reset asserted between edges in the middle of a packet from requester 3.
    in_valid = 4'b1000; in_last = 4'b0000; in_data[3*DW +: DW] = 8'hD0;
    step();
    step();
    in_data[3*DW +: DW] = 8'hD1;
    step();
    in_data[3*DW +: DW] = 8'hD2;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    m_owner = -1;
    m_ptr   = 0;
    step();
    reset = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    step();
    step();
    check("post_reset_gid", 32'(obs_gid), 32'h0);
    in_valid = '0; in_last = '0;
    step();

    // Randomized packet traffic; requesters hold each beat until accepted.
    for (int i = 0; i < NR; i++) rem[i] = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (acc_mask[i]) begin
          if (in_last[i]) begin
            in_valid[i] = 1'b0;
            in_last[i]  = 1'b0;
          end else begin
            rem[i]--;
            in_data[i*DW +: DW] = 8'($urandom);
            in_last[i] = (rem[i] == 1);
          end
        end else if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          rem[i]      = $urandom_range(1, 4);
          in_valid[i] = 1'b1;
          in_data[i*DW +: DW] = 8'($urandom);
          in_last[i]  = (rem[i] == 1);
        end
      end
    end

    // Three-requester instance: the wrap must go 2 -> 0.
    v3 = 3'b111; l3 = 3'b111; ready3 = 1'b1; d3 = 24'($urandom);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        check("nr3_grant", 32'(gid3),  32'(exp3[c/2]));
        check("nr3_busy",  32'(busy3), 32'h1);
      end else begin
        check("nr3_bubble", 32'(busy3), 32'h0);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
